copro_issue_ctrl: RTL

Multi-cycle issue controller for custom-opcode coprocessor instructions (GCD, LCM and future ops) in the single-cycle RISC-V core. It sits beside the main decoder. When an instruction with a custom opcode is decoded, it stalls the core, latches operands and sends them over a valid/ready request channel. It then waits for the result on a valid/ready response channel, with an optional timeout, and produces a one-cycle register-file write-back. The number of custom opcodes, the datapath width and the timeout are parameters.

---
 rtl/copro_issue_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/copro_issue_ctrl.sv
// Issue controller for custom-opcode coprocessor instructions: stalls the core,
// hands latched operands to the coprocessor and writes the result back once.
module copro_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int NUM_OPS = 2,
    parameter int TIMEOUT = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      instr_valid,
    input  logic [6:0]                                op,
    input  logic [4:0]                                rd,
    input  logic [XLEN-1:0]                           rs1_val,
    input  logic [XLEN-1:0]                           rs2_val,
    output logic                                      stall,
    output logic                                      cp_req_valid,
    input  logic                                      cp_req_ready,
    output logic [((NUM_OPS > 1) ? $clog2(NUM_OPS) : 1)-1:0] cp_req_sel,
    output logic [XLEN-1:0]                           cp_req_a,
    output logic [XLEN-1:0]                           cp_req_b,
    input  logic                                      cp_resp_valid,
    input  logic [XLEN-1:0]                           cp_resp_data,
    output logic                                      cp_resp_ready,
    output logic                                      wb_en,
    output logic [4:0]                                wb_rd,
    output logic [XLEN-1:0]                           wb_data,
    output logic                                      cp_error
);

    localparam int SEL_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]       NUM_OPS_V = 8'(NUM_OPS);
    localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             custom;
    logic             timed_out;
    logic [CNT_W-1:0] wait_cnt;

    assign custom    = instr_valid & ({1'b0, op} < NUM_OPS_V);
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A response in the same cycle as the timeout wins.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (custom) state_nxt = S_ISSUE;
            S_ISSUE: if (cp_req_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (cp_resp_valid) begin
                    state_nxt = S_WB;
                end else if (timed_out) begin
                    state_nxt = S_ERR;
                end
            end
            S_WB:    state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Only stall looks at inputs; every other strobe is a pure state decode.
    always_comb begin
        stall         = 1'b0;
        cp_req_valid  = 1'b0;
        cp_resp_ready = 1'b0;
        wb_en         = 1'b0;
        cp_error      = 1'b0;
        case (state)
            S_IDLE:  stall = custom & ~reset;
            S_ISSUE: begin
                stall        = ~reset;
                cp_req_valid = 1'b1;
            end
            S_WAIT: begin
                stall         = ~reset;
                cp_resp_ready = 1'b1;
            end
            S_WB:    wb_en    = |wb_rd;
            S_ERR:   cp_error = 1'b1;
            default: stall    = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cp_req_a   <= '0;
            cp_req_b   <= '0;
            cp_req_sel <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            if (state == S_IDLE && custom) begin
                cp_req_a   <= rs1_val;
                cp_req_b   <= rs2_val;
                cp_req_sel <= op[SEL_W-1:0];
                wb_rd      <= rd;
            end
            if (state == S_WAIT && cp_resp_valid) begin
                wb_data <= cp_resp_data;
            end
        end
    end

    // Counts cycles spent in WAIT; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE && cp_req_ready) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule
